// File: rtl/hazard_sb_unit_pkg.sv
// combi_pkg: shared types and codes for the hazard_sb_unit slice.
//   - RES_* : 2-bit ResultSrc codes driven by the decode stage
//   - FWD_* : 2-bit forward-mux select codes driven to the E stage
//   - hz_stage_t : per-stage hazard-relevant control bits (shadow copy)
//   - hz_match() : register-equality test that honours the RV x0 rule
// Register indices are carried at HZ_IDX_W bits inside the shadow pipe so
// the struct is independent of the unit's REGW parameter (REGW <= HZ_IDX_W).
package combi_pkg;

  localparam int unsigned HZ_IDX_W = 8;
  typedef logic [HZ_IDX_W-1:0] hz_idx_t;

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef struct packed {
    hz_idx_t rs1;
    hz_idx_t rs2;
    hz_idx_t rd;
    logic    regwrite;
    logic    load;
    logic    pcsrc;
  } hz_stage_t;

  // In ARM mode r0 is an ordinary register; in RISC-V mode x0 never
  // carries a dependency.
  function automatic logic hz_match(input hz_idx_t x, input hz_idx_t y,
                                    input logic arm);
    return (x == y) && (arm || (x != '0));
  endfunction

endpackage

// File: rtl/hazard_sb_unit_if.sv
// hazard_sb_unit_if: bundle between the pipeline datapath and the hazard unit.
//   master modport : pipeline side (drives D-stage fields, redirect, memory
//                    request/ack; receives stalls, flushes, forwards).
//   slave modport  : hazard unit side.
// Memory handshake: MemReqM is high while the M-stage instruction has an
// access in flight; MemAckM high in the same cycle completes it. A cycle
// with MemReqM=1 and MemAckM=0 is a wait cycle; MemReqM=1 with MemAckM=1
// is a completion (zero-wait when it is the first cycle of the access).
// wait_cnt exposes the internal wait counter for observation.
interface hazard_sb_unit_if #(
  parameter int REGW = 5,
  parameter int LATW = 4
);
  logic            arm;
  logic [REGW-1:0] Rs1D;
  logic [REGW-1:0] Rs2D;
  logic [REGW-1:0] RdD;
  logic            RegWriteD;
  logic [1:0]      ResultSrcD;
  logic            PCSrcD;
  logic            RedirectE;
  logic            MemReqM;
  logic            MemAckM;

  logic            StallF;
  logic            StallD;
  logic            StallE;
  logic            StallM;
  logic            FlushD;
  logic            FlushE;
  logic            FlushW;
  logic [1:0]      ForwardAE;
  logic [1:0]      ForwardBE;
  logic            MemTimeout;
  logic [LATW-1:0] wait_cnt;

  modport master (
    output arm, Rs1D, Rs2D, RdD, RegWriteD, ResultSrcD, PCSrcD,
           RedirectE, MemReqM, MemAckM,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE, MemTimeout, wait_cnt
  );

  modport slave (
    input  arm, Rs1D, Rs2D, RdD, RegWriteD, ResultSrcD, PCSrcD,
           RedirectE, MemReqM, MemAckM,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE, MemTimeout, wait_cnt
  );
endinterface

// File: rtl/hazard_sb_unit_shadow_pipe.sv
// hz_shadow_pipe: E/M/W shadow copies of hazard-relevant control.
// Ports:
//   clk, rst          : clock, synchronous active-high reset (clears all)
//   stage_d           : D-stage fields as decoded this cycle
//   stall_e, flush_e  : hold / bubble the E shadow register
//   stall_m           : hold both E->M and M->W advance
//   flush_w           : bubble into the W shadow register
//   stage_e/m/w       : registered shadow state
module hz_shadow_pipe
  import combi_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  hz_stage_t stage_d,
  input  logic      stall_e,
  input  logic      flush_e,
  input  logic      stall_m,
  input  logic      flush_w,
  output hz_stage_t stage_e,
  output hz_stage_t stage_m,
  output hz_stage_t stage_w
);

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_e <= '0;
      stage_m <= '0;
      stage_w <= '0;
    end else begin
      // Flush takes priority over hold so a bubble is never masked.
      if (flush_e) begin
        stage_e <= '0;
      end else if (!stall_e) begin
        stage_e <= stage_d;
      end

      if (!stall_m) begin
        stage_m <= stage_e;
      end

      // During a memory wait M is held and W receives a bubble, so the
      // retiring instruction is written back exactly once.
      if (flush_w) begin
        stage_w <= '0;
      end else if (!stall_m) begin
        stage_w <= stage_m;
      end
    end
  end

endmodule

// File: rtl/hazard_sb_unit.sv
// hazard_sb_unit: hazard unit for the dual-ISA (ARM/RISC-V) 5-stage pipeline.
// Tracks E/M/W control in its own shadow pipe so the datapath only drives
// D-stage fields, and resolves forwarding, load-use, ARM PC-write, taken
// redirects and variable-latency data-memory waits.
// Parameters:
//   REGW   : register index width (ARM drives the MSB as 0)
//   LATW   : wait counter width; MemTimeout after 2**LATW-1 wait cycles
//   FWD_EN : 1 = forward from M/W, 0 = resolve every RAW hazard by stalling
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   hz       : hazard_sb_unit_if.slave (D fields, redirect, memory
//              req/ack in; stalls, flushes, forwards, timeout, wait_cnt out)
// All hazard outputs are combinational from shadow state and inputs.
module hazard_sb_unit
  import combi_pkg::*;
#(
  parameter int REGW   = 5,
  parameter int LATW   = 4,
  parameter int FWD_EN = 1
) (
  input logic             clk,
  input logic             rst,
  hazard_sb_unit_if.slave hz
);

  localparam logic [LATW-1:0] CNT_MAX = '1;

  hz_stage_t stage_d;
  hz_stage_t stage_e;
  hz_stage_t stage_m;
  hz_stage_t stage_w;

  logic mem_stall;
  logic ld_stall;
  logic pc_pend;
  logic pc_w;

  logic       stall_f;
  logic       stall_d;
  logic       stall_e;
  logic       stall_m;
  logic       flush_d;
  logic       flush_e;
  logic       flush_w;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  logic [LATW-1:0] cnt_q;
  logic [LATW-1:0] cnt_d;
  logic            timeout_q;

  // Earlier stage p writes a register the D instruction reads.
  function automatic logic reads_dest(input hz_stage_t p, input hz_stage_t d,
                                      input logic arm);
    return p.regwrite &&
           (hz_match(p.rd, d.rs1, arm) || hz_match(p.rd, d.rs2, arm));
  endfunction

  // Youngest producer wins: M ahead of W.
  function automatic logic [1:0] fwd_sel(input hz_idx_t rs,
                                         input hz_stage_t m,
                                         input hz_stage_t w,
                                         input logic arm);
    if (m.regwrite && hz_match(m.rd, rs, arm)) begin
      return FWD_M;
    end
    if (w.regwrite && hz_match(w.rd, rs, arm)) begin
      return FWD_W;
    end
    return FWD_RF;
  endfunction

  always_comb begin
    stage_d          = '0;
    stage_d.rs1      = hz_idx_t'(hz.Rs1D);
    stage_d.rs2      = hz_idx_t'(hz.Rs2D);
    stage_d.rd       = hz_idx_t'(hz.RdD);
    stage_d.regwrite = hz.RegWriteD;
    stage_d.load     = (hz.ResultSrcD == RES_LOAD);
    stage_d.pcsrc    = hz.PCSrcD;
  end

  hz_shadow_pipe u_shadow (
    .clk     (clk),
    .rst     (rst),
    .stage_d (stage_d),
    .stall_e (stall_e),
    .flush_e (flush_e),
    .stall_m (stall_m),
    .flush_w (flush_w),
    .stage_e (stage_e),
    .stage_m (stage_m),
    .stage_w (stage_w)
  );

  always_comb begin
    mem_stall = hz.MemReqM && !hz.MemAckM;

    ld_stall = stage_e.load && reads_dest(stage_e, stage_d, hz.arm);
    if (FWD_EN == 0) begin
      ld_stall = reads_dest(stage_e, stage_d, hz.arm) ||
                 reads_dest(stage_m, stage_d, hz.arm) ||
                 reads_dest(stage_w, stage_d, hz.arm);
    end

    // ARM: a PC write anywhere between D and M blocks fetch until it retires.
    pc_pend = hz.arm && (stage_d.pcsrc || stage_e.pcsrc || stage_m.pcsrc);
    pc_w    = hz.arm && stage_w.pcsrc;
  end

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    fwd_a   = FWD_RF;
    fwd_b   = FWD_RF;

    if (rst) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
      flush_w = 1'b1;
    end else if (mem_stall) begin
      // Freeze F..M; E keeps driving RedirectE, so a taken redirect is
      // simply acted on in the release cycle without being stored here.
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else begin
      // Redirect flushes the D instruction, so it must not also be held;
      // StallF stays up on a load-use so the redirect target is not lost.
      stall_f = ld_stall || pc_pend;
      stall_d = ld_stall && !hz.RedirectE;
      flush_d = hz.RedirectE || pc_pend || pc_w;
      flush_e = ld_stall || hz.RedirectE;
    end

    if (!rst && (FWD_EN != 0)) begin
      fwd_a = fwd_sel(stage_e.rs1, stage_m, stage_w, hz.arm);
      fwd_b = fwd_sel(stage_e.rs2, stage_m, stage_w, hz.arm);
    end
  end

  // Wait counter: counts consecutive wait cycles, saturates at CNT_MAX,
  // clears once the access completes or no access is in flight.
  always_comb begin
    cnt_d = '0;
    if (mem_stall) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + LATW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (mem_stall && (cnt_d == CNT_MAX)) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign hz.StallF     = stall_f;
  assign hz.StallD     = stall_d;
  assign hz.StallE     = stall_e;
  assign hz.StallM     = stall_m;
  assign hz.FlushD     = flush_d;
  assign hz.FlushE     = flush_e;
  assign hz.FlushW     = flush_w;
  assign hz.ForwardAE  = fwd_a;
  assign hz.ForwardBE  = fwd_b;
  assign hz.MemTimeout = timeout_q;
  assign hz.wait_cnt   = cnt_q;

endmodule
